uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
Parametrised parallel-in/serial-out UART transmit serializer, successor to the 8-bit fixed shifter. Accepts a DATA_W-bit word over a valid/ready handshake and frames it as start bit, data bits, optional parity and STOP_BITS stop bits. Each bit is held for CLKS_PER_BIT clocks by an internal bit-period counter. Sits between the TX holding logic and the line driver on the UART transmit path.

Parameters:
DATA_W, 8, data bits per frame (5..9).
CLKS_PER_BIT, 16, clocks per serial bit (>=2).
STOP_BITS, 1, number of stop bits (1 or 2).
LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit DATA_W-1 sent first.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous active-low reset.
data_in  in  DATA_W  word to transmit.
load_valid  in  1  data_in valid.
load_ready  out  1  block can accept a word (high only in IDLE).
tx_out  out  1  serial line; idle/mark = 1.
busy  out  1  a frame is in progress (any state other than IDLE).
done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset is sampled on the clk edge while reset = 0. Outputs after reset: tx_out = 1, load_ready = 1, busy = 0, done = 0. The shift register and counters clear to 0. Reset mid-frame aborts the frame immediately, with no partial stop bit.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx_out = 1, load_ready = 1.
  - On load_valid & load_ready, capture data_in into the shift register. If the parity feature is compiled in, also compute and latch the parity bit.
  - Go to START and clear the bit-period counter.
- Latency: tx_out drives 0 on the cycle after acceptance.
- Bit timing: every state except IDLE lasts exactly CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1, and the state advances when it wraps.
- DATA:
  - tx_out = shift register bit 0 (LSB_FIRST = 1) or bit DATA_W-1 (LSB_FIRST = 0).
  - Shift by one at each bit boundary, filling with 0.
  - A bit index counts 0..DATA_W-1 and leaves DATA after index DATA_W-1.
- STOP: tx_out = 1 for STOP_BITS * CLKS_PER_BIT cycles.
- done: pulses for exactly one cycle, in the first IDLE cycle after STOP.
  - load_ready is also high in that cycle, so a new word may be accepted there.
  - Minimum inter-frame mark time is therefore 1 clock.
- load_valid outside IDLE is ignored. No word is lost silently because load_ready = 0 in those states.
- data_in changes after acceptance have no effect on the frame in progress.
- Frame length, cycles from acceptance to done: (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT + 1, where P = 1 if parity is compiled in, else 0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state exists between DATA and STOP.
  - tx_out = XOR of the captured word, XOR PARITY_ODD.
  - The state lasts CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP. PARITY_ODD is unused.

Decomposition:
- Package uart_pkg:
  - state enum tx_state_t (IDLE, START, DATA, PARITY, STOP).
  - localparam width helpers for the bit-period counter, $clog2(CLKS_PER_BIT), and the bit index counter, $clog2(DATA_W).
  - Shared line constants UART_MARK = 1 and UART_SPACE = 0.
- Sub-module uart_baud_counter:
  - Parametrised by CLKS_PER_BIT, with inputs clr and en.
  - Produces a one-cycle bit_tick on wrap.
  - Will be reused by the receive side.

Test Plan:
- Reset: hold reset = 0 for 3 cycles mid-frame, then release -> tx_out = 1, busy = 0, load_ready = 1, done = 0 on the first cycle after release; no further line activity.
- Basic frame: DATA_W = 8, CLKS_PER_BIT = 4, no parity, send 0xA5 -> tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; done pulses once, 41 cycles after acceptance.
- MSB first with 2 stop bits: LSB_FIRST = 0, STOP_BITS = 2, send 0xA5 -> bit sequence 0,1,0,1,0,0,1,0,1,1,1; stop high for 8 cycles.
- Parity: UART_TX_PARITY_EN defined, send 0xA5 -> parity bit 0 (even) / 1 (odd). Send 0x07 -> parity bit 1 (even) / 0 (odd).
- Handshake: hold load_valid = 1 with 0x3C then 0xC3 -> first word accepted in IDLE; load_ready stays 0 through the whole frame; second word accepted on the done cycle; exactly 1 mark cycle between frames; no words lost or duplicated.
- Abort: assert reset during the DATA state of 0xFF -> tx_out = 1 on the next cycle; the next word 0x00 is transmitted correctly with full-length bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive path.
// Line levels, FSM states and counter width helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_MARK  = 1'b1;
    localparam logic UART_SPACE = 1'b0;

    // Width of a counter covering 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BAUD_CNT_W_DEF = cnt_w(16);
    localparam int BIT_IDX_W_DEF  = cnt_w(8);

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled.
// bit_tick is high in the last clock of each bit period.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = cnt_w(CLKS_PER_BIT);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap     = (cnt == CW'(CLKS_PER_BIT - 1));
    assign bit_tick = en && wrap;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Parametrised UART transmit serializer (start, data, [parity], stop).
// Parity state is built only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int IW = cnt_w(DATA_W);

    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        LSB_FIRST < 0 || LSB_FIRST > 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_serializer: parameter out of range");
    end

    tx_state_t         state;
    tx_state_t         state_nx;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     idx;
    logic              done_r;
    logic              bit_tick;
    logic              last_data;
    logic              last_stop;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign last_data  = (idx == IW'(DATA_W - 1));
    assign last_stop  = (idx == IW'(STOP_BITS - 1));
    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = done_r;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == IDLE),
        .en      (state != IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_nx = state;
        tx_out   = UART_MARK;
        unique case (state)
            IDLE: begin
                if (load_valid) state_nx = START;
            end
            START: begin
                tx_out = UART_SPACE;
                if (bit_tick) state_nx = DATA;
            end
            DATA: begin
                tx_out = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_W-1];
`ifdef UART_TX_PARITY_EN
                if (bit_tick && last_data) state_nx = PARITY;
`else
                if (bit_tick && last_data) state_nx = STOP;
`endif
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                tx_out = parity_bit;
`endif
                if (bit_tick) state_nx = STOP;
            end
            STOP: begin
                if (bit_tick && last_stop) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            shreg  <= '0;
            idx    <= '0;
            done_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            done_r <= (state == STOP) && bit_tick && last_stop;
            unique case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= data_in;
                        idx   <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^data_in) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shreg <= (LSB_FIRST != 0)
                               ? {1'b0, shreg[DATA_W-1:1]}
                               : {shreg[DATA_W-2:0], 1'b0};
                        // idx is reused to count stop bits after DATA
                        idx   <= last_data ? '0 : idx + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
